// File: rtl/amemory_dp_param.sv
// Two-port synchronous memory over one shared array, with configurable read
// latency and read-during-write behaviour, write-collision arbitration and a post-reset clear.
module amemory_dp_param #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 16,
  parameter int READ_LAT   = 1,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic [ADDR_W-1:0] A1,
  input  logic [WIDTH-1:0]  W1,
  input  logic              Write1,
  input  logic              Read1,
  output logic [WIDTH-1:0]  R1,
  output logic              R1_valid,
  input  logic [ADDR_W-1:0] A2,
  input  logic [WIDTH-1:0]  W2,
  input  logic              Write2,
  input  logic              Read2,
  output logic [WIDTH-1:0]  R2,
  output logic              R2_valid,
  output logic              collision,
  output logic [CNT_W-1:0]  collision_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clrAddr_q, clrAddr_d;
  logic              ready_q, ready_d;
  logic              clrWe;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              inRange1, inRange2, sameAddr;
  logic              we1, we2, collide;
  logic [IDX_W-1:0]  idx1, idx2;
  logic [1:0]        re;
  logic [1:0][WIDTH-1:0] rdData;

  logic [1:0]            finValid;
  logic [1:0][WIDTH-1:0] finData;
  logic [1:0]            rValid_q, rValid_d;
  logic [1:0][WIDTH-1:0] rData_q, rData_d;

  logic             collision_q, collision_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (INIT_CLEAR != 0) ? CLEAR : RUN;
      clrAddr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clrAddr_q <= clrAddr_d;
      ready_q   <= ready_d;
    end
  end

  // ready is registered so it rises on the same edge that writes the last clear word
  always_comb begin
    state_d   = state_q;
    clrAddr_d = clrAddr_q;
    ready_d   = ready_q;
    clrWe     = 1'b0;
    case (state_q)
      CLEAR: begin
        clrWe     = 1'b1;
        clrAddr_d = clrAddr_q + ADDR_W'(1);
        if (clrAddr_q == LAST_ADDR) begin
          state_d   = RUN;
          ready_d   = 1'b1;
          clrAddr_d = '0;
        end
      end
      RUN:     ready_d = 1'b1;
      default: state_d = RUN;
    endcase
  end

  assign inRange1 = ({1'b0, A1} < DEPTH_EXT);
  assign inRange2 = ({1'b0, A2} < DEPTH_EXT);
  assign idx1     = A1[IDX_W-1:0];
  assign idx2     = A2[IDX_W-1:0];
  assign sameAddr = (A1 == A2);

  // Port 1 wins a same-address dual write; port 2's write is simply dropped
  assign we1     = ready_q && Write1 && inRange1;
  assign collide = we1 && Write2 && inRange2 && sameAddr;
  assign we2     = ready_q && Write2 && inRange2 && !collide;
  assign re      = {ready_q && Read2, ready_q && Read1};

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clrWe) mem[clrAddr_q[IDX_W-1:0]] <= '0;
      if (we2)   mem[idx2] <= W2;
      if (we1)   mem[idx1] <= W1;
    end
  end

  // Write-first mode forwards the winning write data of either port
  always_comb begin
    rdData = '0;
    if (inRange1) rdData[0] = mem[idx1];
    if (inRange2) rdData[1] = mem[idx2];
    if (RDW_MODE != 0) begin
      if (we2 && sameAddr) rdData[0] = W2;
      if (we1)             rdData[0] = W1;
      if (we2)             rdData[1] = W2;
      if (we1 && sameAddr) rdData[1] = W1;
    end
  end

  generate
    if (READ_LAT == 1) begin : gLat1
      assign finValid = re;
      assign finData  = rdData;
    end else begin : gLat2
      logic [1:0]            s1Valid_q;
      logic [1:0][WIDTH-1:0] s1Data_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          s1Valid_q <= '0;
          s1Data_q  <= '0;
        end else begin
          s1Valid_q <= re;
          s1Data_q  <= rdData;
        end
      end

      assign finValid = s1Valid_q;
      assign finData  = s1Data_q;
    end
  endgenerate

  always_comb begin
    rValid_d = finValid;
    rData_d  = rData_q;
    for (int i = 0; i < 2; i++) begin
      if (finValid[i]) rData_d[i] = finData[i];
    end
    collision_d = collide;
    cnt_d       = cnt_q;
    if (collide && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rValid_q    <= '0;
      rData_q     <= '0;
      collision_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rValid_q    <= rValid_d;
      rData_q     <= rData_d;
      collision_q <= collision_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ready         = ready_q;
  assign R1            = rData_q[0];
  assign R2            = rData_q[1];
  assign R1_valid      = rValid_q[0];
  assign R2_valid      = rValid_q[1];
  assign collision     = collision_q;
  assign collision_cnt = cnt_q;

endmodule

// File: tb/tb_amemory_dp_param.sv
// Directed bench for amemory_dp_param: instance A (16 words, latency 1, read-first, clear on reset)
// and instance B (1000 words, latency 2, write-first, no clear).
module tb_amemory_dp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        reset;
    logic [15:0] a1;
    logic [15:0] w1;
    logic        wr1;
    logic        rd1;
    logic [15:0] a2;
    logic [15:0] w2;
    logic        wr2;
    logic        rd2;
  } reqT;

  typedef struct packed {
    logic        ready;
    logic [15:0] r1;
    logic        r1v;
    logic [15:0] r2;
    logic        r2v;
    logic        col;
    logic [7:0]  cnt;
  } rspT;

  localparam reqT IDLE = '0;

  reqT reqA, reqB;
  rspT rspA, rspB;

  logic        readyA, r1vA, r2vA, colA;
  logic [15:0] r1A, r2A;
  logic [1:0]  cntA;
  logic        readyB, r1vB, r2vB, colB;
  logic [15:0] r1B, r2B;
  logic [7:0]  cntB;

  assign rspA = {readyA, r1A, r1vA, r2A, r2vA, colA, 6'd0, cntA};
  assign rspB = {readyB, r1B, r1vB, r2B, r2vB, colB, cntB};

  amemory_dp_param #(
    .WIDTH(16), .DEPTH(16), .ADDR_W(16), .READ_LAT(1),
    .RDW_MODE(0), .INIT_CLEAR(1), .CNT_W(2)
  ) dutA (
    .clk(clk), .reset(reqA.reset), .ready(readyA),
    .A1(reqA.a1), .W1(reqA.w1), .Write1(reqA.wr1), .Read1(reqA.rd1),
    .R1(r1A), .R1_valid(r1vA),
    .A2(reqA.a2), .W2(reqA.w2), .Write2(reqA.wr2), .Read2(reqA.rd2),
    .R2(r2A), .R2_valid(r2vA),
    .collision(colA), .collision_cnt(cntA)
  );

  amemory_dp_param #(
    .WIDTH(16), .DEPTH(1000), .ADDR_W(16), .READ_LAT(2),
    .RDW_MODE(1), .INIT_CLEAR(0), .CNT_W(8)
  ) dutB (
    .clk(clk), .reset(reqB.reset), .ready(readyB),
    .A1(reqB.a1), .W1(reqB.w1), .Write1(reqB.wr1), .Read1(reqB.rd1),
    .R1(r1B), .R1_valid(r1vB),
    .A2(reqB.a2), .W2(reqB.w2), .Write2(reqB.wr2), .Read2(reqB.rd2),
    .R2(r2B), .R2_valid(r2vB),
    .collision(colB), .collision_cnt(cntB)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input reqT v);
    if (d == 0) reqA = v;
    else        reqB = v;
  endtask

  function automatic rspT sample(input int d);
    return (d == 0) ? rspA : rspB;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input int d, input int port, input logic [15:0] addr, input logic [15:0] data);
    reqT v = IDLE;
    if (port == 1) begin v.wr1 = 1'b1; v.a1 = addr; v.w1 = data; end
    else           begin v.wr2 = 1'b1; v.a2 = addr; v.w2 = data; end
    applyStimulus(d, v);
    tick();
    applyStimulus(d, IDLE);
  endtask

  // Called right after the request edge; instance B needs one more edge
  task automatic finishRead(input int d, input int port, input logic [15:0] exp, input string tag);
    rspT o;
    if (d == 1) begin
      o = sample(d);
      checkOutput({tag, "-early"}, 32'(port == 1 ? o.r1v : o.r2v), 0);
      tick();
    end
    o = sample(d);
    checkOutput({tag, "-valid"}, 32'(port == 1 ? o.r1v : o.r2v), 1);
    checkOutput({tag, "-data"}, 32'(port == 1 ? o.r1 : o.r2), 32'(exp));
  endtask

  task automatic readCheck(input int d, input int port, input logic [15:0] addr, input logic [15:0] exp, input string tag);
    reqT v = IDLE;
    if (port == 1) begin v.rd1 = 1'b1; v.a1 = addr; end
    else           begin v.rd2 = 1'b1; v.a2 = addr; end
    applyStimulus(d, v);
    tick();
    applyStimulus(d, IDLE);
    finishRead(d, port, exp, tag);
  endtask

  task automatic waitReady(input int d, input reqT v, input int expClocks, input string tag);
    int n = 0;
    int pulses = 0;
    rspT o;
    applyStimulus(d, v);
    o = sample(d);
    while (!o.ready && n < 64) begin
      tick();
      n++;
      o = sample(d);
      if (o.r1v || o.r2v) pulses++;
    end
    applyStimulus(d, IDLE);
    checkOutput({tag, "-clocks"}, 32'(n), 32'(expClocks));
    checkOutput({tag, "-noValid"}, 32'(pulses), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reqT v;
    rspT o;

    v = IDLE;
    v.reset = 1'b1;
    applyStimulus(0, v);
    applyStimulus(1, v);
    repeat (3) tick();
    o = sample(0);
    checkOutput("A-rst-ready", 32'(o.ready), 0);
    checkOutput("A-rst-R1", 32'(o.r1), 0);
    checkOutput("A-rst-R1v", 32'(o.r1v), 0);
    checkOutput("A-rst-R2", 32'(o.r2), 0);
    checkOutput("A-rst-R2v", 32'(o.r2v), 0);
    checkOutput("A-rst-col", 32'(o.col), 0);
    checkOutput("A-rst-cnt", 32'(o.cnt), 0);

    waitReady(0, IDLE, 16, "A-clear1");

    for (int i = 0; i < 16; i++) writeWord(0, 1, 16'(i), 16'hA5A5 ^ 16'(i));
    readCheck(0, 2, 4, 16'hA5A1, "A-garbage");

    applyStimulus(0, v);
    repeat (3) tick();
    o = sample(0);
    checkOutput("A-rst2-R2", 32'(o.r2), 0);
    checkOutput("A-rst2-ready", 32'(o.ready), 0);

    // Release, run the clear up to address 8, then reset again
    applyStimulus(0, IDLE);
    repeat (8) tick();
    applyStimulus(0, v);
    repeat (2) tick();
    o = sample(0);
    checkOutput("A-midclr-ready", 32'(o.ready), 0);

    v = IDLE;
    v.wr1 = 1'b1; v.rd1 = 1'b1; v.a1 = 2; v.w1 = 16'h1234;
    v.wr2 = 1'b1; v.rd2 = 1'b1; v.a2 = 9; v.w2 = 16'h4321;
    waitReady(0, v, 16, "A-clear2");

    for (int i = 0; i < 16; i++) readCheck(0, 1 + (i % 2), 16'(i), 0, "A-cleared");

    writeWord(0, 1, 5, 16'hBEEF);
    readCheck(0, 2, 5, 16'hBEEF, "A-basic");
    tick();
    o = sample(0);
    checkOutput("A-hold-R2v", 32'(o.r2v), 0);
    checkOutput("A-hold-R2", 32'(o.r2), 'hBEEF);

    v = IDLE;
    v.rd1 = 1'b1; v.a1 = 5; v.rd2 = 1'b1; v.a2 = 5;
    applyStimulus(0, v);
    tick();
    applyStimulus(0, IDLE);
    o = sample(0);
    checkOutput("A-dualrd-R1", 32'(o.r1), 'hBEEF);
    checkOutput("A-dualrd-R2", 32'(o.r2), 'hBEEF);
    checkOutput("A-dualrd-vld", 32'({o.r1v, o.r2v}), 3);

    v = IDLE;
    v.wr1 = 1'b1; v.a1 = 8; v.w1 = 16'h0808;
    v.wr2 = 1'b1; v.a2 = 9; v.w2 = 16'h0909;
    applyStimulus(0, v);
    tick();
    applyStimulus(0, IDLE);
    checkOutput("A-diffwr-col", 32'(sample(0).col), 0);
    readCheck(0, 1, 8, 16'h0808, "A-diffwr-8");
    readCheck(0, 2, 9, 16'h0909, "A-diffwr-9");

    writeWord(0, 1, 3, 16'hAAAA);
    v = IDLE;
    v.wr1 = 1'b1; v.a1 = 3; v.w1 = 16'h5555; v.rd2 = 1'b1; v.a2 = 3;
    applyStimulus(0, v);
    tick();
    applyStimulus(0, IDLE);
    finishRead(0, 2, 16'hAAAA, "A-rdw-cross");
    readCheck(0, 1, 3, 16'h5555, "A-rdw-after");
    v = IDLE;
    v.wr1 = 1'b1; v.rd1 = 1'b1; v.a1 = 3; v.w1 = 16'h6666;
    applyStimulus(0, v);
    tick();
    applyStimulus(0, IDLE);
    finishRead(0, 1, 16'h5555, "A-rdw-same");
    readCheck(0, 2, 3, 16'h6666, "A-rdw-same-after");

    v = IDLE;
    v.wr1 = 1'b1; v.a1 = 7; v.w1 = 16'h1111;
    v.wr2 = 1'b1; v.a2 = 7; v.w2 = 16'h2222;
    applyStimulus(0, v);
    tick();
    applyStimulus(0, IDLE);
    o = sample(0);
    checkOutput("A-col-pulse", 32'(o.col), 1);
    checkOutput("A-col-cnt1", 32'(o.cnt), 1);
    tick();
    checkOutput("A-col-end", 32'(sample(0).col), 0);
    readCheck(0, 1, 7, 16'h1111, "A-col-mem");
    for (int k = 0; k < 4; k++) begin
      v = IDLE;
      v.wr1 = 1'b1; v.a1 = 16'(10 + k); v.w1 = 16'(k);
      v.wr2 = 1'b1; v.a2 = 16'(10 + k); v.w2 = 16'(k + 256);
      applyStimulus(0, v);
      tick();
    end
    applyStimulus(0, IDLE);
    checkOutput("A-col-sat", 32'(sample(0).cnt), 3);

    writeWord(0, 1, 16, 16'hDEAD);
    readCheck(0, 1, 16, 0, "A-oor");
    readCheck(0, 2, 0, 0, "A-oor-alias0");

    v = IDLE;
    v.reset = 1'b1;
    applyStimulus(0, v);
    tick();
    o = sample(0);
    checkOutput("A-rst3-cnt", 32'(o.cnt), 0);
    checkOutput("A-rst3-R1", 32'(o.r1), 0);
    checkOutput("A-rst3-ready", 32'(o.ready), 0);
    applyStimulus(0, IDLE);

    o = sample(1);
    checkOutput("B-rst-ready", 32'(o.ready), 0);
    checkOutput("B-rst-R1v", 32'(o.r1v), 0);
    checkOutput("B-rst-cnt", 32'(o.cnt), 0);
    waitReady(1, IDLE, 1, "B-ready");

    writeWord(1, 1, 0, 16'h0A0A);
    writeWord(1, 2, 999, 16'h9999);
    writeWord(1, 1, 5, 16'hBEEF);
    writeWord(1, 2, 6, 16'h0606);

    writeWord(1, 1, 1000, 16'hDEAD);
    writeWord(1, 2, 1000, 16'hDEAD);
    readCheck(1, 1, 1000, 0, "B-oor-1000");
    readCheck(1, 2, 16'hFFFF, 0, "B-oor-ffff");
    readCheck(1, 1, 0, 16'h0A0A, "B-oor-mem0");
    readCheck(1, 2, 999, 16'h9999, "B-oor-mem999");

    readCheck(1, 2, 5, 16'hBEEF, "B-lat2");

    v = IDLE;
    v.rd2 = 1'b1; v.a2 = 5;
    applyStimulus(1, v);
    tick();
    v.a2 = 6;
    applyStimulus(1, v);
    tick();
    applyStimulus(1, IDLE);
    o = sample(1);
    checkOutput("B-b2b-v1", 32'(o.r2v), 1);
    checkOutput("B-b2b-d1", 32'(o.r2), 'hBEEF);
    tick();
    o = sample(1);
    checkOutput("B-b2b-v2", 32'(o.r2v), 1);
    checkOutput("B-b2b-d2", 32'(o.r2), 'h0606);
    tick();
    checkOutput("B-b2b-end", 32'(sample(1).r2v), 0);

    writeWord(1, 1, 3, 16'hAAAA);
    v = IDLE;
    v.wr1 = 1'b1; v.a1 = 3; v.w1 = 16'h5555; v.rd2 = 1'b1; v.a2 = 3;
    applyStimulus(1, v);
    tick();
    applyStimulus(1, IDLE);
    finishRead(1, 2, 16'h5555, "B-rdw-cross1");
    v = IDLE;
    v.wr2 = 1'b1; v.a2 = 3; v.w2 = 16'h7777; v.rd1 = 1'b1; v.a1 = 3;
    applyStimulus(1, v);
    tick();
    applyStimulus(1, IDLE);
    finishRead(1, 1, 16'h7777, "B-rdw-cross2");
    v = IDLE;
    v.wr2 = 1'b1; v.rd2 = 1'b1; v.a2 = 3; v.w2 = 16'h8888;
    applyStimulus(1, v);
    tick();
    applyStimulus(1, IDLE);
    finishRead(1, 2, 16'h8888, "B-rdw-same");

    v = IDLE;
    v.wr1 = 1'b1; v.a1 = 7; v.w1 = 16'h1111;
    v.wr2 = 1'b1; v.rd2 = 1'b1; v.a2 = 7; v.w2 = 16'h2222;
    applyStimulus(1, v);
    tick();
    applyStimulus(1, IDLE);
    o = sample(1);
    checkOutput("B-col-pulse", 32'(o.col), 1);
    checkOutput("B-col-cnt", 32'(o.cnt), 1);
    finishRead(1, 2, 16'h1111, "B-col-wf");
    readCheck(1, 1, 7, 16'h1111, "B-col-mem");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/amemory_dp_param.md
Name: amemory_dp_param

Overview:
Parametrised successor to the fixed 16x1k two-port program/data memory. Two independent synchronous read/write ports over one shared array. Adds configurable width/depth, read latency and read-during-write mode, plus deterministic write-collision arbitration and a post-reset clear sequencer with a ready handshake. Sits between the processor datapath (instruction/data ports) and the memory array.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 1024, number of words; need not be a power of two
ADDR_W, 16, address port width; must satisfy 2^ADDR_W >= DEPTH
READ_LAT, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, read-during-write to the same address: 0 = read-first (old data), 1 = write-first (new data)
INIT_CLEAR, 1, 1 = zero the whole array after reset; 0 = skip the clear sequence
CNT_W, 8, width of the saturating collision counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high
ready  output  1  array accepts requests when high
A1  input  ADDR_W  port 1 address
W1  input  WIDTH  port 1 write data
Write1  input  1  port 1 write strobe
Read1  input  1  port 1 read strobe
R1  output  WIDTH  port 1 read data
R1_valid  output  1  R1 updated this cycle
A2, W2, Write2, Read2, R2, R2_valid  same as port 1, for port 2
collision  output  1  one-cycle pulse: same-address dual write resolved
collision_cnt  output  CNT_W  saturating count of collisions

Behaviour:
- Reset (sampled at clk): R1, R2 = 0; R1_valid, R2_valid = 0; collision = 0; collision_cnt = 0; clear address = 0; ready = 0. Array contents not reset except by the clear sequence. Pipeline stages flushed.
- FSM states CLEAR, RUN. Reset forces CLEAR (INIT_CLEAR=1) or RUN (INIT_CLEAR=0).
- CLEAR: each clock with reset low writes 0 to clear address and increments it; after writing DEPTH-1, move to RUN. ready goes high exactly DEPTH clocks after the first clock with reset low. Reset mid-clear restarts at address 0.
- INIT_CLEAR=0: ready = 1 on the first clock after reset deasserts.
- While ready = 0: all port strobes ignored; no valid pulses.
- RUN, write: Writen with An < DEPTH writes Wn at the clock edge.
- RUN, read: Readn accepted; Rn and Rn_valid update READ_LAT clocks later. Rn holds its last value when no read completes; Rn_valid is high only in the completion cycle. For READ_LAT = 2, back-to-back reads pipeline at one per clock.
- Read and write on the same port together are legal; RDW_MODE selects returned data.
- Cross-port read-during-write to the same address obeys RDW_MODE.
- Write collision: Write1 and Write2 to the same in-range address in the same cycle -> port 1 wins and port 2's write is dropped. collision pulses one cycle later. collision_cnt increments and saturates at 2^CNT_W - 1.
- Same-address writes with different data still count as a collision. Same-address reads never collide.
- Out-of-range address (An >= DEPTH): write ignored; read still produces a valid pulse with data 0.
- Two reads to the same address on both ports return identical data.

Test Plan:
- Clear timing: DEPTH=16, INIT_CLEAR=1, preload garbage, reset 3 cycles -> ready rises exactly 16 clocks after reset low; reads of all 16 addresses return 0.
- Basic: write 0xBEEF @A1=5, then Read2 @5 with READ_LAT=1 -> R2 = 0xBEEF and R2_valid high one clock after the read; repeat with READ_LAT=2 -> two clocks, back-to-back reads of 5 then 6 give valid on consecutive clocks.
- Collision: Write1 0x1111 and Write2 0x2222 both @7 -> mem[7] reads 0x1111, collision pulses once, collision_cnt = 1; CNT_W=2 with 5 collisions -> collision_cnt = 3.
- Read-during-write: mem[3] = 0xAAAA; Write1 0x5555 and Read2 @3 in the same cycle -> R2 = 0xAAAA (RDW_MODE=0) or 0x5555 (RDW_MODE=1).
- Out of range: DEPTH=1000, write @1000, read @1000 -> R1 = 0 with R1_valid pulse; mem[0] and mem[999] unchanged.
- Reset mid-clear: assert reset at clear address 8 of 16 -> ready stays low, clear restarts, ready rises 16 clocks after the second reset release; requests issued during clear are ignored (no valid pulse, no write).
